// File: rtl/clock_display_scanner.sv
// Samples H/M/S once per frame, converts each field to BCD by double-dabble and
// scans six 7-segment digits (HH.MM.SS) with colon dots and setting-mode blink.
module clock_display_scanner #(
  parameter int SCAN_DIV  = 10,
  parameter int BLINK_DIV = 5000
) (
  input  logic        clk_10000Hz,
  input  logic        rst_n,
  input  logic [13:0] hours_in,
  input  logic [13:0] minutes_in,
  input  logic [13:0] seconds_in,
  input  logic        blink_enable,
  input  logic        blink_sel,
  output logic [7:0]  seg,
  output logic [5:0]  digit_sel,
  output logic        busy
);

  localparam int DW = (SCAN_DIV  > 1) ? $clog2(SCAN_DIV)  : 1;
  localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  typedef enum logic [1:0] {IDLE, CONV_H, CONV_M, CONV_S} state_t;

  logic              started_q;
  logic [DW-1:0]     div_cnt_q, div_cnt_d;
  logic [2:0]        digit_idx_q, digit_idx_d;
  logic [BW-1:0]     blink_cnt_q, blink_cnt_d;
  logic              blink_phase_q, blink_phase_d;
  logic [5:0][3:0]   shown_q, shown_d;
  logic [5:0][3:0]   pend_q;
  state_t            state_q;
  logic [2:0]        bit_cnt_q;
  logic [14:0]       sh_q, sh_step;
  logic [6:0]        min_q, sec_q;
  logic [7:0]        hbcd_q, mbcd_q;
  logic [7:0]        seg_d;
  logic              frame_start, div_wrap, blink_wrap, blank;
  logic [3:0]        cur_digit;
  logic [6:0]        code;

  function automatic logic [6:0] sat99(input logic [13:0] v);
    return (v > 14'd99) ? 7'd99 : v[6:0];
  endfunction

  // One double-dabble step on {tens, units, binary}: adjust nibbles, then shift.
  function automatic logic [14:0] dd_step(input logic [14:0] v);
    logic [14:0] t;
    t = v;
    if (t[10:7]  >= 4'd5) t[10:7]  = t[10:7]  + 4'd3;
    if (t[14:11] >= 4'd5) t[14:11] = t[14:11] + 4'd3;
    return {t[13:0], 1'b0};
  endfunction

  // The first edge out of reset is treated as a frame start.
  always_comb begin
    div_wrap      = (div_cnt_q == DW'(SCAN_DIV - 1));
    frame_start   = !started_q || (div_wrap && digit_idx_q == 3'd5);
    div_cnt_d     = (frame_start || div_wrap) ? '0 : div_cnt_q + 1'b1;
    digit_idx_d   = frame_start ? 3'd0 : (div_wrap ? digit_idx_q + 3'd1 : digit_idx_q);
    blink_wrap    = (blink_cnt_q == BW'(BLINK_DIV - 1));
    blink_cnt_d   = blink_wrap ? '0 : blink_cnt_q + 1'b1;
    blink_phase_d = blink_phase_q ^ blink_wrap;
    shown_d       = frame_start ? pend_q : shown_q;
    sh_step       = dd_step(sh_q);
  end

  always_comb begin
    cur_digit = shown_d[digit_idx_d];
    code      = 7'h00;
    case (cur_digit)
      4'd0: code = 7'h3F;
      4'd1: code = 7'h06;
      4'd2: code = 7'h5B;
      4'd3: code = 7'h4F;
      4'd4: code = 7'h66;
      4'd5: code = 7'h6D;
      4'd6: code = 7'h7D;
      4'd7: code = 7'h07;
      4'd8: code = 7'h7F;
      4'd9: code = 7'h6F;
      default: code = 7'h00;
    endcase
    blank = blink_enable && blink_phase_d && (digit_idx_d[2:1] == {1'b0, blink_sel});
    seg_d = blank ? 8'h00 : {(digit_idx_d == 3'd1 || digit_idx_d == 3'd3), code};
  end

  always_ff @(posedge clk_10000Hz or negedge rst_n) begin
    if (!rst_n) begin
      started_q     <= 1'b0;
      div_cnt_q     <= '0;
      digit_idx_q   <= 3'd0;
      blink_cnt_q   <= '0;
      blink_phase_q <= 1'b0;
      shown_q       <= '0;
      seg           <= 8'h00;
      digit_sel     <= 6'b0;
    end else begin
      started_q     <= 1'b1;
      div_cnt_q     <= div_cnt_d;
      digit_idx_q   <= digit_idx_d;
      blink_cnt_q   <= blink_cnt_d;
      blink_phase_q <= blink_phase_d;
      shown_q       <= shown_d;
      seg           <= seg_d;
      digit_sel     <= 6'b1 << digit_idx_d;
    end
  end

  // Three back-to-back 7-shift conversions; pending digits commit all at once.
  always_ff @(posedge clk_10000Hz or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      bit_cnt_q <= 3'd0;
      sh_q      <= '0;
      min_q     <= '0;
      sec_q     <= '0;
      hbcd_q    <= '0;
      mbcd_q    <= '0;
      pend_q    <= '0;
      busy      <= 1'b0;
    end else if (frame_start) begin
      state_q   <= CONV_H;
      bit_cnt_q <= 3'd0;
      sh_q      <= {8'h00, sat99(hours_in)};
      min_q     <= sat99(minutes_in);
      sec_q     <= sat99(seconds_in);
      busy      <= 1'b1;
    end else if (state_q != IDLE) begin
      sh_q      <= sh_step;
      bit_cnt_q <= bit_cnt_q + 3'd1;
      if (bit_cnt_q == 3'd6) begin
        bit_cnt_q <= 3'd0;
        case (state_q)
          CONV_H: begin
            hbcd_q  <= sh_step[14:7];
            sh_q    <= {8'h00, min_q};
            state_q <= CONV_M;
          end
          CONV_M: begin
            mbcd_q  <= sh_step[14:7];
            sh_q    <= {8'h00, sec_q};
            state_q <= CONV_S;
          end
          default: begin
            pend_q[0] <= hbcd_q[7:4];
            pend_q[1] <= hbcd_q[3:0];
            pend_q[2] <= mbcd_q[7:4];
            pend_q[3] <= mbcd_q[3:0];
            pend_q[4] <= sh_step[14:11];
            pend_q[5] <= sh_step[10:7];
            busy      <= 1'b0;
            state_q   <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_clock_display_scanner.sv
// Randomised and directed checks of the display scanner against a frame-level model.
module tb_clock_display_scanner;

  localparam int SDIV  = 10;
  localparam int BDIV  = 5000;
  localparam int FRAME = 6 * SDIV;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [13:0] hours = '0, minutes = '0, seconds = '0;
  logic        blink_enable = 1'b0, blink_sel = 1'b0;
  logic [7:0]  seg;
  logic [5:0]  digit_sel;
  logic        busy;

  int n_chk = 0;
  int n_fail = 0;

  logic [6:0] segtab [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
  logic [7:0] zero_tbl [6] = '{8'h3F, 8'hBF, 8'h3F, 8'hBF, 8'h3F, 8'h3F};
  logic [7:0] t123456 [6]  = '{8'h06, 8'hDB, 8'h4F, 8'hE6, 8'h6D, 8'h7D};
  logic [7:0] tsat [6]     = '{8'h6F, 8'hEF, 8'h6F, 8'hEF, 8'h3F, 8'h3F};

  clock_display_scanner #(.SCAN_DIV(SDIV), .BLINK_DIV(BDIV)) dut (
    .clk_10000Hz (clk),
    .rst_n       (rst_n),
    .hours_in    (hours),
    .minutes_in  (minutes),
    .seconds_in  (seconds),
    .blink_enable(blink_enable),
    .blink_sel   (blink_sel),
    .seg         (seg),
    .digit_sel   (digit_sel),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  // Frame-level model: edges since reset, values shown this frame, values captured for next.
  int   m_cyc;
  int   m_shown [3];
  int   m_pend [3];
  logic m_ben, m_bsel;

  function automatic int sat(input int v);
    return (v > 99) ? 99 : v;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_cyc  <= 0;
      m_ben  <= 1'b0;
      m_bsel <= 1'b0;
      for (int i = 0; i < 3; i++) begin
        m_shown[i] <= 0;
        m_pend[i]  <= 0;
      end
    end else begin
      m_cyc  <= m_cyc + 1;
      m_ben  <= blink_enable;
      m_bsel <= blink_sel;
      if (m_cyc % FRAME == 0) begin
        for (int i = 0; i < 3; i++) m_shown[i] <= m_pend[i];
        m_pend[0] <= sat(int'(hours));
        m_pend[1] <= sat(int'(minutes));
        m_pend[2] <= sat(int'(seconds));
      end
    end
  end

  function automatic int cur_idx();
    return ((m_cyc - 1) % FRAME) / SDIV;
  endfunction

  function automatic logic [7:0] exp_seg();
    int idx, fld, v, d;
    logic ph;
    if (m_cyc == 0) return 8'h00;
    idx = cur_idx();
    fld = idx / 2;
    v   = m_shown[fld];
    d   = (idx % 2 == 1) ? v % 10 : v / 10;
    ph  = ((m_cyc / BDIV) % 2) == 1;
    if (m_ben && ph && fld == (m_bsel ? 1 : 0)) return 8'h00;
    return {(idx == 1 || idx == 3), segtab[d]};
  endfunction

  function automatic logic [5:0] exp_dsel();
    if (m_cyc == 0) return 6'b0;
    return 6'(1 << cur_idx());
  endfunction

  function automatic logic exp_busy();
    return (m_cyc >= 1) && (((m_cyc - 1) % FRAME) < 21);
  endfunction

  task automatic apply_reset(input int h, input int m, input int s);
    @(negedge clk);
    #2 rst_n = 1'b0;
    hours = 14'(h); minutes = 14'(m); seconds = 14'(s);
    blink_enable = 1'b0; blink_sel = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    #1;
    n_chk++;
    if (seg !== 8'h00 || digit_sel !== 6'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_initial: seg=%h dsel=%b busy=%b, want 00/000000/0", seg, digit_sel, busy);
    end
    apply_reset(0, 0, 0);
    repeat (33) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_chk++;
    if (seg !== 8'h00 || digit_sel !== 6'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_async: seg=%h dsel=%b busy=%b, want 00/000000/0", seg, digit_sel, busy);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < FRAME; c++) begin
      @(negedge clk);
      n_chk++;
      if (seg !== zero_tbl[c / SDIV] || digit_sel !== 6'(1 << (c / SDIV))) begin
        n_fail++;
        $display("FAIL reset_first_frame c=%0d: seg=%h dsel=%b, want %h/%b",
                 c, seg, digit_sel, zero_tbl[c / SDIV], 6'(1 << (c / SDIV)));
      end
    end
  endtask

  task automatic test_conversion();
    int busy_cycles = 0;
    apply_reset(12, 34, 56);
    for (int c = 0; c < 2 * FRAME; c++) begin
      @(negedge clk);
      if (c < FRAME && busy === 1'b1) busy_cycles++;
      if (c == 0) begin
        n_chk++;
        if (busy !== 1'b1) begin
          n_fail++;
          $display("FAIL conv_busy_start: busy=%b, want 1", busy);
        end
      end
      if (c >= FRAME) begin
        n_chk++;
        if (seg !== t123456[(c - FRAME) / SDIV]) begin
          n_fail++;
          $display("FAIL conv_frame2 c=%0d: seg=%h, want %h", c, seg, t123456[(c - FRAME) / SDIV]);
        end
      end
    end
    n_chk++;
    if (busy_cycles != 21) begin
      n_fail++;
      $display("FAIL conv_busy_len: busy cycles=%0d, want 21", busy_cycles);
    end
  endtask

  task automatic test_saturation();
    apply_reset(150, 99, 0);
    repeat (FRAME) @(negedge clk);
    for (int c = 0; c < FRAME; c++) begin
      @(negedge clk);
      n_chk++;
      if (seg !== tsat[c / SDIV]) begin
        n_fail++;
        $display("FAIL saturation c=%0d: seg=%h, want %h", c, seg, tsat[c / SDIV]);
      end
    end
  endtask

  task automatic test_blink();
    logic [7:0] want;
    apply_reset(12, 34, 56);
    blink_enable = 1'b1;
    blink_sel = 1'b1;
    repeat (BDIV - 51) @(negedge clk);
    for (int c = 0; c < 150; c++) begin
      @(negedge clk);
      want = t123456[cur_idx()];
      if (m_cyc >= BDIV && (cur_idx() == 2 || cur_idx() == 3)) want = 8'h00;
      n_chk++;
      if (seg !== want || seg !== exp_seg() || digit_sel !== exp_dsel()) begin
        n_fail++;
        $display("FAIL blink_on cyc=%0d: seg=%h dsel=%b, want %h/%b", m_cyc, seg, digit_sel, want, exp_dsel());
      end
    end
    while (m_cyc < 2 * BDIV - 50) @(negedge clk);
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      n_chk++;
      if (seg !== exp_seg() || digit_sel !== exp_dsel()) begin
        n_fail++;
        $display("FAIL blink_off_phase cyc=%0d: seg=%h, want %h", m_cyc, seg, exp_seg());
      end
    end
    while (m_cyc < 3 * BDIV + 50) @(negedge clk);
    blink_enable = 1'b0;
    for (int c = 0; c < FRAME; c++) begin
      @(negedge clk);
      n_chk++;
      if (seg !== t123456[cur_idx()]) begin
        n_fail++;
        $display("FAIL blink_disabled cyc=%0d: seg=%h, want %h", m_cyc, seg, t123456[cur_idx()]);
      end
    end
  endtask

  task automatic test_midframe_change();
    apply_reset(12, 34, 56);
    for (int c = 0; c < 4 * FRAME; c++) begin
      @(negedge clk);
      n_chk++;
      if (seg !== exp_seg() || digit_sel !== exp_dsel()) begin
        n_fail++;
        $display("FAIL midframe cyc=%0d: seg=%h dsel=%b, want %h/%b", m_cyc, seg, digit_sel, exp_seg(), exp_dsel());
      end
      if (m_cyc == 3 * FRAME + 35) begin
        n_chk++;
        if (seg !== 8'hED) begin
          n_fail++;
          $display("FAIL midframe_update: seg=%h, want ED", seg);
        end
      end
      if (m_cyc == FRAME + 4 * SDIV + 1) minutes = 14'd35;
    end
  endtask

  task automatic test_reset_midconv();
    apply_reset(12, 34, 56);
    while (m_cyc < FRAME + 4) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_chk++;
    if (busy !== 1'b0 || seg !== 8'h00) begin
      n_fail++;
      $display("FAIL midconv_reset: busy=%b seg=%h, want 0/00", busy, seg);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 2 * FRAME; c++) begin
      @(negedge clk);
      n_chk++;
      if (seg !== (c < FRAME ? zero_tbl[c / SDIV] : t123456[(c - FRAME) / SDIV]) ||
          seg !== exp_seg() || busy !== exp_busy()) begin
        n_fail++;
        $display("FAIL midconv_after c=%0d: seg=%h busy=%b, want %h/%b", c, seg, busy, exp_seg(), exp_busy());
      end
    end
  endtask

  function automatic int rand_field();
    return ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 16383)) : int'($urandom_range(0, 120));
  endfunction

  task automatic test_random();
    for (int it = 0; it < 6; it++) begin
      apply_reset(rand_field(), rand_field(), rand_field());
      blink_enable = 1'($urandom_range(0, 1));
      blink_sel = 1'($urandom_range(0, 1));
      for (int c = 0; c < 4 * FRAME; c++) begin
        @(negedge clk);
        n_chk++;
        if (seg !== exp_seg() || digit_sel !== exp_dsel() || busy !== exp_busy()) begin
          n_fail++;
          $display("FAIL random it=%0d cyc=%0d: seg=%h dsel=%b busy=%b, want %h/%b/%b",
                   it, m_cyc, seg, digit_sel, busy, exp_seg(), exp_dsel(), exp_busy());
        end
        if ($urandom_range(0, 29) == 0) begin
          hours = 14'(rand_field());
          minutes = 14'(rand_field());
          seconds = 14'(rand_field());
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_conversion();
    test_saturation();
    test_midframe_change();
    test_reset_midconv();
    test_random();
    test_blink();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
